lcd_ctrl16x2: RTL and testbench
===============================

# lcd_ctrl16x2

Drives a 16x2 HD44780-compatible character LCD in 4-bit write-only mode. It consumes the 256-bit, 32-character ASCII frame produced by the register-to-BCD formatter: line 1 is `chars[255:128]` and line 2 is `chars[127:0]`, most significant byte leftmost. After power-up it runs the controller init sequence once, then refreshes both lines continuously. It sits between the formatter and the board LCD pins.

## Interface
Delay parameters are in clock cycles; defaults assume a 50 MHz clock.
- T_POWERUP, 750000, wait after reset before the first init nibble (15 ms).
- T_INIT1, 205000, wait after the first 0x3 nibble (4.1 ms).
- T_INIT2, 5000, wait after the second 0x3 nibble (100 us).
- T_SU, 2, setup time: `lcd_rs`/`lcd_d` valid before `lcd_e` rises.
- T_E, 12, `lcd_e` high width.
- T_NIB, 50, gap after the high nibble of a byte (1 us).
- T_CMD, 2000, wait after a complete byte, and after init nibbles 3 and 4 (40 us).
- T_CLR, 82000, wait after the clear-display byte (1.64 ms).

Ports:
- `clk` input 1: system clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `chars` input 256: ASCII frame; byte `[255:248]` is line 1 column 0, byte `[7:0]` is line 2 column 15.
- `lcd_e` output 1: LCD enable strobe.
- `lcd_rs` output 1: 0 = command, 1 = data.
- `lcd_rw` output 1: tied to 0 (write only).
- `lcd_d` output 4: LCD data bus DB7..DB4.
- `ready` output 1: high once init completes; stays high until reset.
- `frame_done` output 1: one-cycle pulse at the end of each full 32-character refresh.

## Operation
Reset values: all outputs are 0, the FSM is in PWRUP, and all counters are 0.

Nibble engine (one nibble):
- SU: drive `lcd_rs`/`lcd_d`, `lcd_e`=0, for T_SU cycles.
- EH: `lcd_e`=1 for T_E cycles.
- WT: `lcd_e`=0 for the post-wait.
- `lcd_rs` and `lcd_d` hold their values through WT; they change only at the next SU.

Byte write:
- High nibble first, with post-wait T_NIB.
- Then the low nibble, with post-wait T_CMD, or T_CLR for command 0x01.

Top FSM:
- PWRUP: wait T_POWERUP.
- INIT: single nibbles with `lcd_rs`=0: 0x3 (wait T_INIT1), 0x3 (wait T_INIT2), 0x3 (wait T_CMD), 0x2 (wait T_CMD).
- CFG: command bytes 0x28, 0x06, 0x0C, 0x01. After the 0x01 post-wait, `ready` goes to 1.
- ADDR1: latch `chars` into the internal frame buffer on entry, then write command 0x80.
- LINE1: 16 data bytes (`lcd_rs`=1) from buffer `[255:128]`, MSB byte first.
- ADDR2: command 0xC0.
- LINE2: 16 data bytes from buffer `[127:0]`.
- At the end of the last byte's post-wait: `frame_done`=1 for one cycle, same cycle as re-entering ADDR1. Loop forever.

Boundary rules:
- `chars` is sampled only on entry to ADDR1. Changes mid-frame appear in the next frame only.
- No content check: any byte value, including 0x00, is written as-is.
- `rst_n` low at any time, including mid-EH: all outputs go to 0 immediately (asynchronously). On release the block restarts from PWRUP and repeats the full init.
- Wait counters are wide enough for T_POWERUP; a zero-valued parameter is treated as 1 cycle.

## Timing
- Nibble period: T_SU + T_E + post-wait.
- Byte period: 2·(T_SU+T_E) + T_NIB + T_CMD. At defaults this is 2078 cycles.
- Frame period (ADDR1 entry to ADDR1 entry): 34 byte periods, i.e. 70652 cycles at defaults. `frame_done` pulses are exactly one frame period apart.
- `lcd_e` rises exactly T_SU cycles after `lcd_rs`/`lcd_d` change and stays high exactly T_E cycles.
- Time from `rst_n` release to `ready` = T_POWERUP + (T_SU+T_E)·4 + T_INIT1 + T_INIT2 + 2·T_CMD + 3·byte period + 2·(T_SU+T_E) + T_NIB + T_CLR. A ±1-cycle tolerance is allowed only for the first cycle after reset release.
- `lcd_rw` is 0 in every cycle.

## Test plan
Bench parameters: T_POWERUP=100, T_INIT1=40, T_INIT2=10, T_SU=2, T_E=3, T_NIB=4, T_CMD=8, T_CLR=20, giving byte = 22 cycles and frame = 748 cycles. The monitor decodes (`lcd_rs`, `lcd_d`) on each `lcd_e` falling edge.

1. Init sequence: reset, then release. Required:
   - all outputs are 0 during reset;
   - first `lcd_e` rise occurs at cycle 102;
   - nibbles are 3,3,3,2, 2,8, 0,6, 0,C, 0,1, all with `lcd_rs`=0;
   - `ready` rises only after the 20-cycle clear wait.
2. Frame content: `chars` = "ST$1$2$3$4PCMDAO0105070912A3FF04". Required:
   - command 0x80, then 16 data bytes "ST$1$2$3$4PCMDAO";
   - command 0xC0, then 16 data bytes "0105070912A3FF04";
   - exactly one `frame_done` pulse per frame, with pulses 748 cycles apart.
3. Snapshot: change `chars` line 1 to "XXXXXXXXXXXXXXXX" during the 5th LINE1 byte. Required: the current frame is unchanged, and the next frame shows all X on line 1.
4. Strobe timing: over 3 frames, every `lcd_e` high lasts exactly 3 cycles, and `lcd_rs`/`lcd_d` are constant from 2 cycles before each rise through the following SU.
5. Reset mid-strobe: drive `rst_n` low while `lcd_e`=1 in LINE2. Required:
   - `lcd_e`, `lcd_rs`, `lcd_d`, `ready` are 0 in the same cycle;
   - after release, the first `lcd_e` rise is again at cycle 102 and the init sequence repeats exactly.
6. Data-value edge: `chars` with bytes 0x00 and 0xFF. Required: these bytes appear as nibbles 0,0 and F,F with `lcd_rs`=1, and `lcd_rw` is 0 throughout.

Source files
------------

// File: rtl/lcd_ctrl16x2_if.sv
// Formatter-to-LCD bundle: character frame in, HD44780 4-bit write pins and status out.
interface lcd_ctrl16x2_if;
  logic [255:0] chars;
  logic         lcd_e;
  logic         lcd_rs;
  logic         lcd_rw;
  logic [3:0]   lcd_d;
  logic         ready;
  logic         frame_done;

  modport master (
    input  chars,
    output lcd_e, lcd_rs, lcd_rw, lcd_d, ready, frame_done
  );

  modport slave (
    output chars,
    input  lcd_e, lcd_rs, lcd_rw, lcd_d, ready, frame_done
  );
endinterface

// File: rtl/lcd_ctrl16x2.sv
// 16x2 HD44780 driver, 4-bit write-only: one-shot init, then endless two-line refresh
// from a frame buffer snapshotted at the start of each frame.
module lcd_ctrl16x2 #(
  parameter int unsigned T_POWERUP = 750000,
  parameter int unsigned T_INIT1   = 205000,
  parameter int unsigned T_INIT2   = 5000,
  parameter int unsigned T_SU      = 2,
  parameter int unsigned T_E       = 12,
  parameter int unsigned T_NIB     = 50,
  parameter int unsigned T_CMD     = 2000,
  parameter int unsigned T_CLR     = 82000
) (
  input  logic             clk,
  input  logic             rst_n,
  lcd_ctrl16x2_if.master   bus
);

  typedef enum logic [2:0] {
    S_PWRUP, S_INIT, S_CFG, S_ADDR1, S_LINE1, S_ADDR2, S_LINE2
  } state_t;

  typedef enum logic [1:0] {PH_SU, PH_EH, PH_WT} phase_t;

  function automatic logic [31:0] f_cyc(input int unsigned t);
    return (t == 0) ? 32'd1 : 32'(t);
  endfunction

  state_t         r_state, w_state_nx;
  phase_t         r_ph, w_ph_nx;
  logic [31:0]    r_cnt, w_cnt_nx;
  logic [3:0]     r_idx, w_idx_nx;
  logic           r_lo, w_lo_nx;
  logic [255:0]   r_buf;
  logic           r_ready, r_frame_done;
  logic           w_load, w_fd, w_rdy;
  logic [127:0]   w_line;
  logic [7:0]     w_byte;
  logic [3:0]     w_nib;
  logic           w_rs;
  logic [31:0]    w_post, w_len;
  logic           w_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_PWRUP;
      r_ph         <= PH_SU;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_lo         <= 1'b0;
      r_buf        <= '0;
      r_ready      <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_ph         <= w_ph_nx;
      r_cnt        <= w_cnt_nx;
      r_idx        <= w_idx_nx;
      r_lo         <= w_lo_nx;
      r_frame_done <= w_fd;
      if (w_load) r_buf   <= bus.chars;
      if (w_rdy)  r_ready <= 1'b1;
    end
  end

  always_comb begin
    w_line = (r_state == S_LINE2) ? r_buf[127:0] : r_buf[255:128];
    w_rs   = (r_state == S_LINE1) || (r_state == S_LINE2);
    case (r_state)
      S_CFG: begin
        case (r_idx[1:0])
          2'd0:    w_byte = 8'h28;
          2'd1:    w_byte = 8'h06;
          2'd2:    w_byte = 8'h0C;
          default: w_byte = 8'h01;
        endcase
      end
      S_ADDR1:          w_byte = 8'h80;
      S_ADDR2:          w_byte = 8'hC0;
      S_LINE1, S_LINE2: w_byte = w_line[{~r_idx, 3'b000} +: 8];
      default:          w_byte = 8'h00;
    endcase

    // Init nibbles are sent alone; everything else is high nibble then low nibble.
    if (r_state == S_INIT) begin
      w_nib = (r_idx == 4'd3) ? 4'h2 : 4'h3;
      case (r_idx)
        4'd0:    w_post = f_cyc(T_INIT1);
        4'd1:    w_post = f_cyc(T_INIT2);
        default: w_post = f_cyc(T_CMD);
      endcase
    end else begin
      w_nib = r_lo ? w_byte[3:0] : w_byte[7:4];
      if (!r_lo)                         w_post = f_cyc(T_NIB);
      else if (!w_rs && w_byte == 8'h01) w_post = f_cyc(T_CLR);
      else                               w_post = f_cyc(T_CMD);
    end

    if (r_state == S_PWRUP) w_len = f_cyc(T_POWERUP);
    else begin
      case (r_ph)
        PH_SU:   w_len = f_cyc(T_SU);
        PH_EH:   w_len = f_cyc(T_E);
        default: w_len = w_post;
      endcase
    end
    w_done = (r_cnt == w_len - 32'd1);

    w_state_nx = r_state;
    w_ph_nx    = r_ph;
    w_idx_nx   = r_idx;
    w_lo_nx    = r_lo;
    w_cnt_nx   = r_cnt + 32'd1;
    w_load     = 1'b0;
    w_fd       = 1'b0;
    w_rdy      = 1'b0;
    if (w_done) begin
      w_cnt_nx = '0;
      if (r_state == S_PWRUP) begin
        w_state_nx = S_INIT;
        w_ph_nx    = PH_SU;
        w_idx_nx   = '0;
        w_lo_nx    = 1'b0;
      end else begin
        case (r_ph)
          PH_SU: w_ph_nx = PH_EH;
          PH_EH: w_ph_nx = PH_WT;
          default: begin
            w_ph_nx = PH_SU;
            if (r_state == S_INIT) begin
              if (r_idx == 4'd3) begin
                w_state_nx = S_CFG;
                w_idx_nx   = '0;
              end else w_idx_nx = r_idx + 4'd1;
            end else if (!r_lo) begin
              w_lo_nx = 1'b1;
            end else begin
              w_lo_nx  = 1'b0;
              w_idx_nx = r_idx + 4'd1;
              case (r_state)
                S_CFG: if (r_idx == 4'd3) begin
                  w_state_nx = S_ADDR1;
                  w_idx_nx   = '0;
                  w_load     = 1'b1;
                  w_rdy      = 1'b1;
                end
                S_ADDR1: begin
                  w_state_nx = S_LINE1;
                  w_idx_nx   = '0;
                end
                S_LINE1: if (r_idx == 4'd15) w_state_nx = S_ADDR2;
                S_ADDR2: begin
                  w_state_nx = S_LINE2;
                  w_idx_nx   = '0;
                end
                S_LINE2: if (r_idx == 4'd15) begin
                  w_state_nx = S_ADDR1;
                  w_load     = 1'b1;
                  w_fd       = 1'b1;
                end
                default: ;
              endcase
            end
          end
        endcase
      end
    end
  end

  always_comb begin
    bus.lcd_rw     = 1'b0;
    bus.lcd_e      = (r_state != S_PWRUP) && (r_ph == PH_EH);
    bus.lcd_rs     = w_rs;
    bus.lcd_d      = (r_state == S_PWRUP) ? 4'h0 : w_nib;
    bus.ready      = r_ready;
    bus.frame_done = r_frame_done;
  end

endmodule

// File: tb/tb_lcd_ctrl16x2.sv
// Directed bench for lcd_ctrl16x2 with short delays; nibbles decoded on each lcd_e fall.
module tb_lcd_ctrl16x2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lcd_ctrl16x2_if bus();

  lcd_ctrl16x2 #(
    .T_POWERUP(100), .T_INIT1(40), .T_INIT2(10), .T_SU(2),
    .T_E(3), .T_NIB(4), .T_CMD(8), .T_CLR(20)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Monitor: cycle count since reset release, nibble capture and strobe timing.
  logic [4:0] q[$];
  int cyc = 0, first_rise = 0, ready_cyc = 0, last_fall = 0;
  int fd_n = 0, fd_last = 0, fd_prev = 0, rw_bad = 0, ecnt = 0;
  logic e_p = 1'b0, e_p2 = 1'b0;
  logic [4:0] h1 = '0, h2 = '0, at_rise = '0, cur;

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      cyc = 0; e_p = 1'b0; e_p2 = 1'b0; ecnt = 0;
      first_rise = 0; ready_cyc = 0;
    end else begin
      cyc++;
      cur = {bus.lcd_rs, bus.lcd_d};
      if (bus.lcd_rw !== 1'b0) rw_bad++;
      if (bus.lcd_e && !e_p) begin
        if (first_rise == 0) first_rise = cyc;
        if (cyc > 2) begin
          chk("setup_data", {h2, h1}, {cur, cur});
          chk("setup_e_low", {e_p2, e_p}, 2'b00);
        end
        at_rise = cur;
      end
      if (bus.lcd_e) ecnt++;
      if (!bus.lcd_e && e_p) begin
        q.push_back(h1);
        last_fall = cyc;
        chk("e_width", ecnt, 3);
        chk("hold_through_eh", cur, at_rise);
        ecnt = 0;
      end
      if (bus.ready && ready_cyc == 0) ready_cyc = cyc;
      if (bus.frame_done) begin
        fd_n++; fd_prev = fd_last; fd_last = cyc;
      end
      h2 = h1; h1 = cur; e_p2 = e_p; e_p = bus.lcd_e;
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ready;
    for (int i = 0; i < 400 && ready_cyc == 0; i++) tick();
    chk("ready_seen", ready_cyc != 0, 1'b1);
  endtask

  task automatic wait_q(input int n);
    for (int i = 0; i < 800 && q.size() < n; i++) tick();
    chk("nibble_wait", q.size() >= n, 1'b1);
  endtask

  task automatic wait_fd;
    int base;
    base = fd_n;
    for (int i = 0; i < 800 && fd_n == base; i++) tick();
    chk("frame_done_wait", fd_n == base + 1, 1'b1);
  endtask

  task automatic check_init(input string tag);
    logic [3:0] exp_n [12];
    exp_n = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'h6, 4'h0, 4'hC, 4'h0, 4'h1};
    chk({tag, "_first_rise"}, first_rise, 102);
    chk({tag, "_ready_cyc"}, ready_cyc, 286);
    chk({tag, "_clear_wait"}, ready_cyc - last_fall, 20);
    chk({tag, "_nibbles"}, q.size(), 12);
    for (int i = 0; i < 12; i++)
      if (i < q.size()) chk($sformatf("%s_nib%0d", tag, i), q[i], {1'b0, exp_n[i]});
  endtask

  task automatic check_frame(input string tag, input logic [127:0] l1, input logic [127:0] l2);
    logic [127:0] s;
    logic [7:0] b;
    logic rs;
    chk({tag, "_len"}, q.size(), 68);
    for (int k = 0; k < 34; k++) begin
      if (k == 0) begin b = 8'h80; rs = 1'b0; end
      else if (k < 17) begin s = l1 << (8 * (k - 1)); b = s[127:120]; rs = 1'b1; end
      else if (k == 17) begin b = 8'hC0; rs = 1'b0; end
      else begin s = l2 << (8 * (k - 18)); b = s[127:120]; rs = 1'b1; end
      if (2 * k + 1 < q.size())
        chk($sformatf("%s_byte%0d", tag, k),
            {q[2*k][4], q[2*k+1][4], q[2*k][3:0], q[2*k+1][3:0]}, {rs, rs, b});
    end
  endtask

  task automatic after_pulse(input string tag);
    q.delete();
    tick();
    chk({tag, "_fd_one_cycle"}, bus.frame_done, 1'b0);
  endtask

  logic [127:0] a1, a2, x1, c1, c2;

  initial begin
    a1 = "ST$1$2$3$4PCMDAO";
    a2 = "0105070912A3FF04";
    x1 = "XXXXXXXXXXXXXXXX";
    c1 = {8{8'h00, 8'hFF}};
    c2 = {8{8'hFF, 8'h00}};
    bus.chars = {a1, a2};

    repeat (5) tick();
    chk("rst_e", bus.lcd_e, 1'b0);
    chk("rst_rs", bus.lcd_rs, 1'b0);
    chk("rst_rw", bus.lcd_rw, 1'b0);
    chk("rst_d", bus.lcd_d, 4'h0);
    chk("rst_ready", bus.ready, 1'b0);
    chk("rst_fd", bus.frame_done, 1'b0);

    @(negedge clk) rst_n = 1'b1;
    wait_ready();
    check_init("init");
    q.delete();

    wait_fd();
    chk("fd1_cyc", fd_last, 1034);
    check_frame("frame1", a1, a2);
    after_pulse("frame1");

    wait_q(11);
    bus.chars[255:128] = x1;
    wait_fd();
    chk("fd2_period", fd_last - fd_prev, 748);
    check_frame("frame2", a1, a2);
    after_pulse("frame2");

    wait_q(20);
    bus.chars = {c1, c2};
    wait_fd();
    chk("fd3_period", fd_last - fd_prev, 748);
    check_frame("frame3", x1, a2);
    after_pulse("frame3");

    wait_fd();
    chk("fd4_period", fd_last - fd_prev, 748);
    check_frame("frame4", c1, c2);
    after_pulse("frame4");
    chk("ready_held", bus.ready, 1'b1);

    wait_q(39);
    for (int i = 0; i < 60 && bus.lcd_e !== 1'b1; i++) tick();
    chk("pre_rst_e", bus.lcd_e, 1'b1);
    chk("pre_rst_rs", bus.lcd_rs, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_e", bus.lcd_e, 1'b0);
    chk("mid_rst_rs", bus.lcd_rs, 1'b0);
    chk("mid_rst_d", bus.lcd_d, 4'h0);
    chk("mid_rst_ready", bus.ready, 1'b0);
    chk("mid_rst_fd", bus.frame_done, 1'b0);
    repeat (3) tick();
    q.delete();
    @(negedge clk) rst_n = 1'b1;
    wait_ready();
    check_init("reinit");

    chk("rw_always_low", rw_bad, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
